// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin burst arbiter driving the mux8_16 select
// Optional feature macro: MUX8_ARB_LOCK_EN (adds lock_i, suppresses burst-limit release)
module mux8_rr_arbiter #(
    parameter int NumReq   = 8,
    parameter int SelWidth = 3,
    parameter int MaxBurst = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumReq-1:0]   req_i,
    input  logic                ready_i,
`ifdef MUX8_ARB_LOCK_EN
    input  logic [NumReq-1:0]   lock_i,
`endif
    output logic [SelWidth-1:0] sel_o,
    output logic [NumReq-1:0]   gnt_o,
    output logic                valid_o,
    output logic                busy_o
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    // Last legal counter value; the counter never goes past it.
    localparam logic [7:0] LastCnt = 8'(MaxBurst - 1);

    logic [0:0]          state_q, state_d;
    logic [SelWidth-1:0] owner_q, owner_d;
    logic [SelWidth-1:0] ptr_q, ptr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NumReq-1:0]   gnt_q, gnt_d;

    logic [SelWidth-1:0] search_base;
    logic [SelWidth-1:0] scan_idx;
    logic [SelWidth-1:0] winner;
    logic                win_found;

    logic                granted;
    logic                owner_req;
    logic                beat;
    logic                at_limit;
    logic                locked;
    logic                release_grant;

    assign granted   = (state_q == StGrant);
    assign owner_req = req_i[owner_q];
    assign valid_o   = granted && owner_req;
    assign beat      = valid_o && ready_i;
    assign at_limit  = (cnt_q == LastCnt);

`ifdef MUX8_ARB_LOCK_EN
    assign locked = lock_i[owner_q];
`else
    assign locked = 1'b0;
`endif

    // Dropping the request always ends the burst; the beat limit only does so when unlocked.
    assign release_grant = granted && (!owner_req || (beat && at_limit && !locked));

    // While granted, the only search that matters is the one on release, which
    // starts just past the current owner so the old owner ranks last.
    assign search_base = granted ? (owner_q + SelWidth'(1)) : ptr_q;

    // Rotating priority search: scan from the highest offset down so the
    // lowest offset from search_base is the last one to overwrite the result.
    always_comb begin
        winner    = search_base;
        win_found = 1'b0;
        scan_idx  = search_base;
        for (int i = NumReq - 1; i >= 0; i--) begin
            scan_idx = search_base + SelWidth'(i);
            if (req_i[scan_idx]) begin
                winner    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // Next-state logic for grant ownership, rr pointer and beat counter.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    owner_d = winner;
                    cnt_d   = 8'd0;
                    gnt_d   = NumReq'(1) << winner;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    ptr_d = owner_q + SelWidth'(1);
                    cnt_d = 8'd0;
                    if (win_found) begin
                        owner_d = winner;
                        gnt_d   = NumReq'(1) << winner;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else if (beat && !at_limit) begin
                    // Saturates at LastCnt, which only happens while locked.
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers; reset drops any burst in progress immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Owner doubles as the mux select and keeps its value through idle.
    assign sel_o  = owner_q;
    assign gnt_o  = gnt_q;
    assign busy_o = granted;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - self-checking scoreboard bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req   = 8'h00;
    logic       ready = 1'b0;
    logic [7:0] lock  = 8'h00;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;
    logic       busy;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(
        .NumReq   (8),
        .SelWidth (3),
        .MaxBurst (MAX_BURST)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .ready_i (ready),
`ifdef MUX8_ARB_LOCK_EN
        .lock_i  (lock),
`endif
        .sel_o   (sel),
        .gnt_o   (gnt),
        .valid_o (valid),
        .busy_o  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit       busy;
        bit [2:0] sel;
        bit [7:0] gnt;
    } exp_t;

    exp_t sb_q[$];

    bit       m_busy;
    bit [2:0] m_owner;
    bit [2:0] m_ptr;
    int       m_beats;

    function automatic bit [3:0] pick(input bit [7:0] r, input bit [2:0] base);
        for (int k = 0; k < 8; k++) begin
            bit [2:0] c;
            c = base + 3'(k);
            if (r[c]) return {1'b1, c};
        end
        return 4'b0;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 3'd0;
        m_ptr   = 3'd0;
        m_beats = 0;
        sb_q.delete();
    endtask

    task automatic model_step(input bit [7:0] r, input bit rd, input bit lk);
        bit [3:0] p;
        bit       has;
        bit       bt;
        bit       done;
        if (!m_busy) begin
            p = pick(r, m_ptr);
            if (p[3]) begin
                m_busy  = 1'b1;
                m_owner = p[2:0];
                m_beats = 0;
            end
        end else begin
            has  = r[m_owner];
            bt   = has && rd;
            done = !has || (bt && (m_beats + 1 >= MAX_BURST) && !lk);
            if (done) begin
                m_ptr = m_owner + 3'd1;
                p     = pick(r, m_ptr);
                if (p[3]) begin
                    m_owner = p[2:0];
                    m_beats = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (bt && m_beats < MAX_BURST - 1) begin
                m_beats++;
            end
        end
    endtask

    // One clock: drive at negedge, push expectation, compare after posedge, return at negedge.
    task automatic cycle(input bit [7:0] r, input bit rd);
        exp_t e;
        req   = r;
        ready = rd;
        #1;
        check_eq("valid", valid, m_busy && r[m_owner]);
        model_step(r, rd, lock[m_owner]);
        e.busy = m_busy;
        e.sel  = m_owner;
        e.gnt  = m_busy ? (8'd1 << m_owner) : 8'd0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = sb_q.pop_front();
            check_eq("gnt", gnt, e.gnt);
            check_eq("sel", sel, e.sel);
            check_eq("busy", busy, e.busy);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        ready = 1'b0;
        lock  = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset with every requester asking
        #1;
        rst_n = 1'b0;
        req   = 8'hFF;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_gnt", gnt, 8'h00);
        check_eq("rst_sel", sel, 3'd0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;
        model_reset();

        // Single requester: grant one cycle later, regranted after each burst
        cycle(8'h04, 1'b1);
        check_eq("single_gnt", gnt, 8'h04);
        check_eq("single_sel", sel, 3'd2);
        repeat (9) cycle(8'h04, 1'b1);
        check_eq("single_regrant", gnt, 8'h04);

        // Fairness between 0 and 7 in 4-beat blocks
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            cycle(8'h81, 1'b1);
            check_eq("rr_owner", sel, (((k - 1) / 4) % 2 == 1) ? 3'd7 : 3'd0);
        end

        // Backpressure on owner 3, requester 5 waiting
        do_reset();
        cycle(8'h28, 1'b1);
        check_eq("bp_first", sel, 3'd3);
        for (int i = 0; i < 6; i++) begin
            cycle(8'h28, pat[i]);
            check_eq("bp_sel", sel, (i < 5) ? 3'd3 : 3'd5);
        end

        // Early drop by owner 6, pointer wraps to 0
        do_reset();
        cycle(8'h40, 1'b1);
        cycle(8'h43, 1'b1);
        cycle(8'h43, 1'b1);
        cycle(8'h03, 1'b1);
        check_eq("wrap_sel", sel, 3'd0);
        check_eq("wrap_gnt", gnt, 8'h01);

        // Asynchronous reset in the middle of a burst
        do_reset();
        cycle(8'h10, 1'b1);
        cycle(8'h10, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", gnt, 8'h00);
        check_eq("arst_sel", sel, 3'd0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_valid", valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX8_ARB_LOCK_EN
        // Locked owner 1 holds past the burst limit until its request drops
        do_reset();
        lock = 8'h02;
        repeat (5) cycle(8'h03, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(8'h03, 1'b1);
            check_eq("lock_hold", sel, 3'd1);
        end
        cycle(8'h01, 1'b1);
        check_eq("lock_drop", sel, 3'd0);
        lock = 8'h00;
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            bit [7:0] r;
            r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
`ifdef MUX8_ARB_LOCK_EN
            lock = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
`endif
            cycle(r, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the 8:1 16-bit multiplexer datapath (`mux8_16`). Eight requesters share the mux: the block picks one owner, drives the mux select, and holds it for a bounded burst of beats. Beats are counted with a valid/ready handshake toward the downstream consumer. It sits beside the mux in the same clock domain, and its `sel_o` connects directly to the mux `sel_i`.

## Interface
- `NumReq`, 8: number of requesters; fixed at 8 to match the mux inputs.
- `SelWidth`, 3: select width, equal to $clog2(NumReq).
- `MaxBurst`, 4: maximum beats per grant; legal range 1..255.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `req_i`  in  8  per-requester request; bit n high means requester n has data on mux input n.
- `ready_i`  in  1  downstream ready for the current mux output beat.
- `sel_o`  out  3  registered mux select; equals the current owner index.
- `gnt_o`  out  8  registered one-hot grant; all zero when idle.
- `valid_o`  out  1  output beat valid; combinational: state is GRANT and `req_i[owner]` is high.
- `busy_o`  out  1  high while state is GRANT.

## Operation
- State machine has two states: IDLE and GRANT.
- Registers: owner (3b), rr pointer `ptr` (3b), beat counter `cnt` (8b).
- A beat occurs on any cycle where `valid_o` and `ready_i` are both high.
- Winner search: the first set bit of `req_i`, scanning `ptr`, `ptr`+1, … and wrapping modulo 8.
- **IDLE**:
  - If `req_i` is nonzero: owner <= winner, `cnt` <= 0, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**:
  - Release condition R is either of:
    - `req_i[owner]` == 0, or
    - a beat occurs while `cnt` == MaxBurst-1.
  - Without R: `cnt` increments on each beat.
  - On R:
    - `ptr` <= owner+1 (mod 8).
    - Compute the winner using the new pointer value (owner+1) against the current `req_i`.
    - If a winner exists: owner <= winner, `cnt` <= 0, stay in GRANT. This is a switch with no idle cycle.
    - Otherwise go to IDLE.
  - When the burst limit releases the grant, the old owner ranks last in the search. It is regranted only if it is the sole requester.
- `sel_o` = owner and `gnt_o` = 1<<owner, both registered and updated together. `gnt_o` is 0 in IDLE.
- `sel_o` holds its last value in IDLE, so the mux input does not change needlessly.
- Requester protocol: a requester may drop `req_i` at any time. Dropping it forfeits the rest of its burst.

## Timing
- Reset values: state IDLE, `ptr` 0, owner 0, `cnt` 0, `sel_o` 0, `gnt_o` 0, `busy_o` 0, `valid_o` 0.
- Request to grant: a request seen at cycle t in IDLE gives `gnt_o`/`sel_o` valid at t+1.
- `valid_o` is combinational and can be high at t+1.
- Grant handover: the release beat at cycle t gives the new owner's `gnt_o`/`sel_o` at t+1. No idle cycle is inserted when another request is pending.
- Throughput: one beat per cycle while `ready_i` is high.
- `ready_i` low stalls `cnt`. The grant is held indefinitely while `req_i[owner]` stays high.
- Reset asserted mid-burst: all registers return to their reset values immediately. A burst in progress is dropped with no completion.
- The counter must never exceed MaxBurst-1.
- MaxBurst=1 degenerates to strict per-beat round-robin.

## Configuration
- Macro: `MUX8_ARB_LOCK_EN`.
- Defined:
  - Adds port `lock_i` (in, 8).
  - While `lock_i[owner]` is high, the burst-limit release is suppressed. The grant ends only when `req_i[owner]` drops.
  - `cnt` saturates at MaxBurst-1 while locked.
  - Lock is sampled every cycle, so deasserting it with `cnt` == MaxBurst-1 releases the grant on the next beat.
- Undefined: the `lock_i` port is absent and the burst limit is always enforced.

## Test plan
- Reset check: hold `rst_ni`=0 with `req_i`=8'hFF. Expect `gnt_o`=0, `sel_o`=0, `valid_o`=0, `busy_o`=0.
- Single requester: `req_i`=8'h04 for 10 cycles with `ready_i`=1. Expect:
  - `gnt_o`=8'h04 and `sel_o`=2 one cycle after the request.
  - A 4-beat burst, then regrant to 2, because it is the sole requester.
- Round-robin fairness: `req_i`=8'h81 held, `ready_i`=1, MaxBurst=4. Expect owners 0,7,0,7 in 4-beat blocks with no gap cycles.
- Backpressure: owner 3 with `ready_i` toggling 1,0,0,1,1,1. Expect release only after the 4th accepted beat, with `sel_o`=3 stable throughout.
- Early drop and wrap: owner 6 drops `req_i` after 2 beats while `req_i`=8'h03 is pending. Expect the next owner to be 0, i.e. `ptr` wraps 7→0.
- Async reset mid-burst, plus lock with `MUX8_ARB_LOCK_EN`:
  - Assert `rst_ni` low mid-burst: outputs go to 0 immediately.
  - With the macro defined, `lock_i[1]`=1, and `req_i`=8'h03: owner 1 keeps the grant for more than 4 beats, until `req_i[1]` drops.
